load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/rv_pkg.sv | 41 ++++
 rtl/load_store_unit_if.sv | 20 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I load/store codes, LSU state encoding and latched-operand record.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [2:0]  funct3;
    logic        store;
    logic [4:0]  rd;
  } lsu_req_t;

  // funct3[1:0] encodes access size for every legal code: 0 byte, 1 half, 2 word.
  function automatic logic lsu_legal(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] lo);
    logic ok_code;
    logic ok_align;
    if (ld) ok_code = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    else    ok_code = f3 inside {F3_SB, F3_SH, F3_SW};
    case (f3[1:0])
      2'd1:    ok_align = !lo[0];
      2'd2:    ok_align = (lo == 2'b00);
      default: ok_align = 1'b1;
    endcase
    return (ld ^ st) && ok_code && ok_align;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
interface load_store_unit_if;
  logic        o_MemReq;
  logic        o_MemWe;
  logic [31:0] o_MemAddr;
  logic [31:0] o_MemWdata;
  logic [3:0]  o_MemBe;
  logic        i_MemAck;
  logic [31:0] i_MemRdata;

  modport master (
    output o_MemReq, o_MemWe, o_MemAddr, o_MemWdata, o_MemBe,
    input  i_MemAck, i_MemRdata
  );

  modport slave (
    input  o_MemReq, o_MemWe, o_MemAddr, o_MemWdata, o_MemBe,
    output i_MemAck, i_MemRdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replication, load lane select and extension.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        store,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] lane;
  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    if (store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << off;
          wdata = {4{sdata[7:0]}};
        end
        F3_SH: begin
          be    = 4'b0011 << off;
          wdata = {2{sdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ldata = lane;
    case (funct3)
      F3_LB:  ldata = {{24{lane[7]}}, lane[7:0]};
      F3_LH:  ldata = {{16{lane[15]}}, lane[15:0]};
      F3_LBU: ldata = {24'd0, lane[7:0]};
      F3_LHU: ldata = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates, issues one bus access, waits for ack or timeout.
module load_store_unit
  import rv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Valid,
  input  logic        i_fLoad,
  input  logic        i_fStore,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_StoreData,
  input  logic [4:0]  i_Rd,
  output logic        o_Stall,
  load_store_unit_if.master mem,
  output logic        o_Valid,
  output logic [31:0] o_Data,
  output logic [4:0]  o_Rd,
  output logic        o_fFault,
  output logic        o_fBusErr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state, state_nxt;
  lsu_req_t    req;
  logic [7:0]  cnt;
  logic        accept, fault_now, pass_now, ack_now, to_now;
  logic        busy;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;

  assign busy = (state == ST_BUSY);

  always_comb begin
    state_nxt = state;
    o_Stall   = 1'b0;
    accept    = 1'b0;
    fault_now = 1'b0;
    pass_now  = 1'b0;
    ack_now   = 1'b0;
    to_now    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Valid && (i_fLoad || i_fStore)) begin
          if (lsu_legal(i_fLoad, i_fStore, i_Funct3, i_Addr[1:0])) begin
            accept    = 1'b1;
            o_Stall   = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            fault_now = 1'b1;
          end
        end else if (i_Valid) begin
          pass_now = 1'b1;
        end
      end
      ST_BUSY: begin
        // Ack beats a coincident timeout.
        if (mem.i_MemAck) begin
          ack_now   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          to_now    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          o_Stall = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state     <= ST_IDLE;
      req       <= '0;
      cnt       <= '0;
      o_Valid   <= 1'b0;
      o_Data    <= '0;
      o_Rd      <= '0;
      o_fFault  <= 1'b0;
      o_fBusErr <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_Valid   <= 1'b0;
      o_fFault  <= 1'b0;
      o_fBusErr <= 1'b0;
      if (accept) begin
        req <= '{addr: i_Addr, sdata: i_StoreData, funct3: i_Funct3,
                 store: i_fStore, rd: i_Rd};
        cnt <= '0;
      end
      if (busy && !ack_now && !to_now) cnt <= cnt + 8'd1;
      if (pass_now) begin
        o_Valid <= 1'b1;
        o_Data  <= i_Addr;
        o_Rd    <= i_Rd;
      end
      if (fault_now) begin
        o_Valid  <= 1'b1;
        o_fFault <= 1'b1;
        o_Data   <= '0;
        o_Rd     <= i_Rd;
      end
      if (ack_now) begin
        o_Valid <= 1'b1;
        o_Data  <= req.store ? 32'd0 : ldata;
        o_Rd    <= req.rd;
      end
      if (to_now) begin
        o_Valid   <= 1'b1;
        o_fBusErr <= 1'b1;
        o_Data    <= '0;
        o_Rd      <= req.rd;
      end
    end
  end

  lsu_align u_align (
    .funct3 (req.funct3),
    .off    (req.addr[1:0]),
    .store  (req.store),
    .sdata  (req.sdata),
    .rdata  (mem.i_MemRdata),
    .be     (be),
    .wdata  (wdata),
    .ldata  (ldata)
  );

  // Bus outputs are forced low outside BUSY so reset clears them immediately.
  assign mem.o_MemReq   = busy;
  assign mem.o_MemWe    = busy & req.store;
  assign mem.o_MemAddr  = busy ? {req.addr[31:2], 2'b00} : 32'd0;
  assign mem.o_MemWdata = busy ? wdata : 32'd0;
  assign mem.o_MemBe    = busy ? be : 4'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4 and hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_Valid = 1'b0, i_fLoad = 1'b0, i_fStore = 1'b0;
  logic [2:0]  i_Funct3 = '0;
  logic [31:0] i_Addr = '0, i_StoreData = '0;
  logic [4:0]  i_Rd = '0;
  logic        o_Stall, o_Valid, o_fFault, o_fBusErr;
  logic [31:0] o_Data;
  logic [4:0]  o_Rd;
  int          checks = 0, errors = 0;

  load_store_unit_if mem();

  load_store_unit #(.TIMEOUT(4)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(i_Valid), .i_fLoad(i_fLoad), .i_fStore(i_fStore),
    .i_Funct3(i_Funct3), .i_Addr(i_Addr), .i_StoreData(i_StoreData), .i_Rd(i_Rd),
    .o_Stall(o_Stall), .mem(mem), .o_Valid(o_Valid), .o_Data(o_Data), .o_Rd(o_Rd),
    .o_fFault(o_fFault), .o_fBusErr(o_fBusErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one instruction for the coming posedge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    i_Valid = 1'b1; i_fLoad = ld; i_fStore = st; i_Funct3 = f3;
    i_Addr = a; i_StoreData = sd; i_Rd = rd;
  endtask

  task automatic idle_in();
    i_Valid = 1'b0; i_fLoad = 1'b0; i_fStore = 1'b0;
  endtask

  // Issue a load, ack it in the first BUSY cycle, check the writeback.
  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'd0, 5'd3);
    @(negedge clk); idle_in();
    mem.i_MemRdata = rdata; mem.i_MemAck = 1'b1;
    @(negedge clk); mem.i_MemAck = 1'b0;
    chk(tag, o_Data, exp);
  endtask

  task automatic fault_case(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a);
    issue(ld, st, f3, a, 32'd0, 5'd4);
    #1 chk({tag, "_stall"}, 32'(o_Stall), 32'd0);
    @(negedge clk); idle_in();
    chk({tag, "_fault"}, 32'({o_Valid, o_fFault, mem.o_MemReq}), 32'b110);
    chk({tag, "_data"}, o_Data, 32'd0);
  endtask

  int  n;
  logic last_stall;

  initial begin
    mem.i_MemAck = 1'b0; mem.i_MemRdata = '0;
    #1;
    chk("rst_outs", 32'({o_Valid, o_fFault, o_fBusErr, mem.o_MemReq, o_Stall}), 32'd0);
    chk("rst_data", o_Data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // pass-through
    issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
    #1 chk("pt_stall", 32'(o_Stall), 32'd0);
    @(negedge clk); idle_in();
    chk("pt_valid", 32'({o_Valid, mem.o_MemReq}), 32'b10);
    chk("pt_data", o_Data, 32'h0000_1234);
    chk("pt_rd", 32'(o_Rd), 32'd5);
    @(negedge clk);
    chk("pt_pulse", 32'(o_Valid), 32'd0);
    chk("pt_hold", o_Data, 32'h0000_1234);

    // LB at 0x103, ack in third BUSY cycle
    issue(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 5'd7);
    #1 chk("lb_stall0", 32'(o_Stall), 32'd1);
    @(negedge clk); idle_in();
    chk("lb_req", 32'({mem.o_MemReq, mem.o_MemWe, mem.o_MemBe}), 32'b10_1111);
    chk("lb_addr", mem.o_MemAddr, 32'h0000_0100);
    chk("lb_stall1", 32'(o_Stall), 32'd1);
    @(negedge clk);
    chk("lb_stall2", 32'(o_Stall), 32'd1);
    @(negedge clk);
    mem.i_MemRdata = 32'h80FF_0000; mem.i_MemAck = 1'b1;
    #1 chk("lb_stall_ack", 32'(o_Stall), 32'd0);
    @(negedge clk); mem.i_MemAck = 1'b0;
    chk("lb_valid", 32'({o_Valid, o_fFault, o_fBusErr, mem.o_MemReq}), 32'b1000);
    chk("lb_data", o_Data, 32'hFFFF_FF80);
    chk("lb_rd", 32'(o_Rd), 32'd7);

    // SH at 0x202
    issue(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd9);
    @(negedge clk); idle_in();
    chk("sh_be", 32'({mem.o_MemWe, mem.o_MemBe}), 32'b1_1100);
    chk("sh_wdata", mem.o_MemWdata, 32'hABCD_ABCD);
    chk("sh_addr", mem.o_MemAddr, 32'h0000_0200);
    mem.i_MemAck = 1'b1;
    #1 chk("sh_stall_ack", 32'(o_Stall), 32'd0);
    @(negedge clk); mem.i_MemAck = 1'b0;
    chk("sh_done", 32'({o_Valid, o_Rd}), 32'b1_01001);
    chk("sh_data", o_Data, 32'd0);

    // SB at 0x501
    issue(1'b0, 1'b1, 3'd0, 32'h0000_0501, 32'h1234_5678, 5'd2);
    @(negedge clk); idle_in();
    chk("sb_be", 32'(mem.o_MemBe), 32'b0010);
    chk("sb_wdata", mem.o_MemWdata, 32'h7878_7878);
    mem.i_MemAck = 1'b1;
    @(negedge clk); mem.i_MemAck = 1'b0;

    // load extension variants
    load_case("lh_data",  3'd1, 32'h0000_0302, 32'h8001_1234, 32'hFFFF_8001);
    load_case("lhu_data", 3'd5, 32'h0000_0302, 32'h8001_1234, 32'h0000_8001);
    load_case("lbu_data", 3'd4, 32'h0000_0101, 32'h0000_F200, 32'h0000_00F2);
    load_case("lw_data",  3'd2, 32'h0000_0400, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // faults
    fault_case("lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_0201);
    fault_case("ld_f3", 1'b1, 1'b0, 3'd3, 32'h0000_0000);
    fault_case("st_f3", 1'b0, 1'b1, 3'd4, 32'h0000_0000);
    fault_case("sh_mis", 1'b0, 1'b1, 3'd1, 32'h0000_0003);
    fault_case("ld_st", 1'b1, 1'b1, 3'd0, 32'h0000_0000);
    @(negedge clk);
    chk("fault_pulse", 32'({o_Valid, o_fFault}), 32'd0);

    // timeout: no ack
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0600, 32'd0, 5'd11);
    @(negedge clk); idle_in();
    n = 0; last_stall = 1'b1;
    while (mem.o_MemReq && n < 20) begin
      n++; last_stall = o_Stall;
      @(negedge clk);
    end
    chk("to_cycles", n, 32'd4);
    chk("to_exit_stall", 32'(last_stall), 32'd0);
    chk("to_err", 32'({o_Valid, o_fBusErr, o_fFault}), 32'b110);
    chk("to_data", o_Data, 32'd0);
    @(negedge clk);
    chk("to_pulse", 32'({o_Valid, o_fBusErr}), 32'd0);

    // ack coinciding with the timeout cycle
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0700, 32'd0, 5'd12);
    @(negedge clk); idle_in();
    repeat (3) @(negedge clk);
    mem.i_MemRdata = 32'h1122_3344; mem.i_MemAck = 1'b1;
    @(negedge clk); mem.i_MemAck = 1'b0;
    chk("ack4_flags", 32'({o_Valid, o_fBusErr}), 32'b10);
    chk("ack4_data", o_Data, 32'h1122_3344);

    // stray ack in IDLE
    mem.i_MemAck = 1'b1;
    @(negedge clk); mem.i_MemAck = 1'b0;
    chk("stray_ack", 32'({o_Valid, mem.o_MemReq}), 32'd0);

    // reset mid-BUSY
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0800, 32'd0, 5'd13);
    @(negedge clk); idle_in();
    chk("rb_req", 32'(mem.o_MemReq), 32'd1);
    rst = 1'b0;
    #1 chk("rb_drop", 32'({mem.o_MemReq, o_Stall, o_Valid}), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rb_novalid", 32'(o_Valid), 32'd0);
    load_case("rb_after", 3'd4, 32'h0000_0803, 32'h7F00_0000, 32'h0000_007F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
